// File: rtl/data_c_pipe_intc_s2m_verc_with_id_pkg.sv
// data_c_pipe_intc_s2m_verc_with_id_pkg: shared constants and helpers for the id-steered return demux
package data_c_pipe_intc_s2m_verc_with_id_pkg;
  localparam int DROP_W = 16;
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/data_c_pipe_intc_s2m_verc_with_id_if.sv
// data_c_pipe_intc_s2m_verc_with_id_if: valid/ready data stream with master and slave views
interface data_c_pipe_intc_s2m_verc_with_id_if #(parameter int DSIZE = 8) ();
  logic [DSIZE-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, output valid, input ready);
  modport slave(input data, input valid, output ready);
endinterface

// File: rtl/data_c_skid_buf.sv
// data_c_skid_buf: one-entry skid buffer with registered ready, bypass when downstream accepts
module data_c_skid_buf #(parameter int W = 8) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic full, full_nxt, acc;
  logic [W-1:0] buf_q;
  assign acc = in_valid && in_ready;
  assign out_valid = full || acc;
  assign out_data = full ? buf_q : in_data;
  assign full_nxt = full ? !out_ready : acc && !out_ready;
  // hold the stalled beat; ready is simply "skid empty next cycle", low throughout reset
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      full <= 1'b0;
      in_ready <= 1'b0;
      buf_q <= '0;
    end else begin
      full <= full_nxt;
      in_ready <= !full_nxt;
      if (!full && acc && !out_ready) buf_q <= in_data;
    end
endmodule

// File: rtl/data_c_pipe_intc_s2m_verc_with_id.sv
// data_c_pipe_intc_s2m_verc_with_id: one stream steered to NUM outputs by a per-beat id, illegal ids dropped
module data_c_pipe_intc_s2m_verc_with_id
  import data_c_pipe_intc_s2m_verc_with_id_pkg::*;
#(
  parameter int NUM = 8,
  parameter int IDSIZE = 3
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [IDSIZE-1:0]   sid,
  data_c_pipe_intc_s2m_verc_with_id_if.slave  s00,
  data_c_pipe_intc_s2m_verc_with_id_if.master m00 [NUM],
  output logic [DROP_W-1:0]   drop_cnt
);
  localparam int DSIZE = $bits(s00.data);
  localparam int W = DSIZE + IDSIZE;
  if (NUM < 2 || (2 ** IDSIZE) < NUM) begin : g_bad_cfg
    $error("NUM must be >= 2 and fit in IDSIZE bits");
  end
  logic [W-1:0] sk_data;
  logic [IDSIZE-1:0] sk_id;
  logic [DSIZE-1:0] sk_dat;
  logic sk_valid, sk_ready, legal, take, load, drain;
  logic out_vld;
  logic [IDSIZE-1:0] out_id;
  logic [DSIZE-1:0] out_data;
  logic [NUM-1:0] hit, rdy;
  data_c_skid_buf #(.W(W)) u_skid (
    .clock(clock),
    .rst_n(rst_n),
    .in_data({sid, s00.data}),
    .in_valid(s00.valid),
    .in_ready(s00.ready),
    .out_data(sk_data),
    .out_valid(sk_valid),
    .out_ready(sk_ready)
  );
  assign {sk_id, sk_dat} = sk_data;
  assign legal = int'(sk_id) < NUM;
  assign drain = out_vld && |(hit & rdy);
  assign sk_ready = !legal || !out_vld || drain;
  assign take = sk_valid && sk_ready;
  assign load = take && legal;
  for (genvar k = 0; k < NUM; k++) begin : g_out
    assign hit[k] = out_id == IDSIZE'(k);
    assign rdy[k] = m00[k].ready;
    assign m00[k].valid = out_vld && hit[k];
    assign m00[k].data = out_data;
  end
  // output stage: reload on every take of a legal beat, otherwise empty on drain
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_id <= '0;
      out_data <= '0;
    end else if (load) begin
      out_vld <= 1'b1;
      out_id <= sk_id;
      out_data <= sk_dat;
    end else if (drain) begin
      out_vld <= 1'b0;
    end
  // count beats swallowed for out-of-range ids, sticking at all-ones
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (take && !legal) drop_cnt <= sat_inc(drop_cnt);
endmodule

// File: tb/tb_data_c_pipe_intc_s2m_verc_with_id.sv
// tb_data_c_pipe_intc_s2m_verc_with_id: scoreboard bench for NUM=8 and NUM=5 instances
module tb_data_c_pipe_intc_s2m_verc_with_id;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  data_c_pipe_intc_s2m_verc_with_id_if #(.DSIZE(16)) s8 ();
  data_c_pipe_intc_s2m_verc_with_id_if #(.DSIZE(16)) m8 [8] ();
  data_c_pipe_intc_s2m_verc_with_id_if #(.DSIZE(16)) s5 ();
  data_c_pipe_intc_s2m_verc_with_id_if #(.DSIZE(16)) m5 [5] ();
  logic [2:0] sid8, sid5;
  logic [15:0] drop8, drop5;
  logic [7:0] r8, v8;
  logic [4:0] r5, v5;
  logic [15:0] d8 [8];
  logic [15:0] d5 [5];
  for (genvar g = 0; g < 8; g++) begin : g_m8
    assign m8[g].ready = r8[g];
    assign v8[g] = m8[g].valid;
    assign d8[g] = m8[g].data;
  end
  for (genvar g = 0; g < 5; g++) begin : g_m5
    assign m5[g].ready = r5[g];
    assign v5[g] = m5[g].valid;
    assign d5[g] = m5[g].data;
  end
  data_c_pipe_intc_s2m_verc_with_id #(.NUM(8), .IDSIZE(3)) dut8 (
    .clock(clock), .rst_n(rst_n), .sid(sid8), .s00(s8), .m00(m8), .drop_cnt(drop8)
  );
  data_c_pipe_intc_s2m_verc_with_id #(.NUM(5), .IDSIZE(3)) dut5 (
    .clock(clock), .rst_n(rst_n), .sid(sid5), .s00(s5), .m00(m5), .drop_cnt(drop5)
  );
  typedef struct {
    int id;
    logic [15:0] d;
    int cyc;
  } exp_t;
  exp_t q8[$];
  exp_t q5[$];
  int nvec = 0;
  int nerr = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // scoreboard for the 8-way instance: every delivered beat must be the oldest expected one
  always @(negedge clock) begin
    if (rst_n && v8 != 0) begin
      chk("m8 single valid", 64'($onehot(v8)), 1);
      for (int k = 0; k < 8; k++) begin
        if (v8[k] && r8[k]) begin
          if (q8.size() == 0) chk("m8 unexpected beat", k + 100, 64'hFFFF);
          else begin
            automatic exp_t e = q8.pop_front();
            chk("m8 dest", k, e.id);
            chk("m8 data", d8[k], e.d);
            if (e.cyc >= 0) chk("m8 latency", cyc, e.cyc);
          end
        end
      end
    end
  end
  // scoreboard for the 5-way instance
  always @(negedge clock) begin
    if (rst_n && v5 != 0) begin
      chk("m5 single valid", 64'($onehot(v5)), 1);
      for (int k = 0; k < 5; k++) begin
        if (v5[k] && r5[k]) begin
          if (q5.size() == 0) chk("m5 unexpected beat", k + 100, 64'hFFFF);
          else begin
            automatic exp_t e = q5.pop_front();
            chk("m5 dest", k, e.id);
            chk("m5 data", d5[k], e.d);
            if (e.cyc >= 0) chk("m5 latency", cyc, e.cyc);
          end
        end
      end
    end
  end
  task automatic send8(input int id, input logic [15:0] d, input bit push, input bit lat);
    int n = 0;
    sid8 = id[2:0];
    s8.data = d;
    s8.valid = 1'b1;
    while (!s8.ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!s8.ready) chk("s8 accept timeout", s8.ready, 1);
    @(posedge clock); #1;
    if (push) q8.push_back('{id: id, d: d, cyc: lat ? cyc : -1});
  endtask
  task automatic send5(input int id, input logic [15:0] d, input bit push, input bit lat);
    int n = 0;
    sid5 = id[2:0];
    s5.data = d;
    s5.valid = 1'b1;
    while (!s5.ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!s5.ready) chk("s5 accept timeout", s5.ready, 1);
    @(posedge clock); #1;
    if (push) q5.push_back('{id: id, d: d, cyc: lat ? cyc : -1});
  endtask
  task automatic wait_empty8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("m8 drain pending", q8.size(), 0);
  endtask
  task automatic wait_empty5();
    int n = 0;
    while (q5.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("m5 drain pending", q5.size(), 0);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    sid8 = '0; sid5 = '0; s8.data = '0; s5.data = '0;
    r8 = '1; r5 = '1;
    s8.valid = 1'b1; s5.valid = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("rst s8 ready", s8.ready, 0);
    chk("rst m8 valid", v8, 0);
    chk("rst m8 data", d8[0] | d8[7], 0);
    chk("rst drop8", drop8, 0);
    chk("rst s5 ready", s5.ready, 0);
    chk("rst m5 valid", v5, 0);
    chk("rst drop5", drop5, 0);
    s8.valid = 1'b0; s5.valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clock); #1;
    chk("release s8 ready", s8.ready, 1);
    chk("release s5 ready", s5.ready, 1);
    for (int i = 0; i < 16; i++) send8(i % 8, 16'(i), 1, 1);
    s8.valid = 1'b0;
    wait_empty8();
    r8[3] = 1'b0;
    send8(3, 16'hA3, 1, 0);
    send8(5, 16'hB5, 1, 0);
    chk("bp s8 ready low", s8.ready, 0);
    fork
      send8(5, 16'hC5, 1, 0);
      begin
        repeat (10) @(posedge clock);
        #1;
        chk("bp only m8[3] valid", v8, 8'h08);
        chk("bp held data", d8[3], 16'hA3);
        r8[3] = 1'b1;
      end
    join
    s8.valid = 1'b0;
    wait_empty8();
    chk("drop8 after legal traffic", drop8, 0);
    chk("ill s5 ready a", s5.ready, 1);
    send5(6, 16'h0061, 0, 1);
    chk("ill s5 ready b", s5.ready, 1);
    send5(1, 16'h0011, 1, 1);
    chk("ill s5 ready c", s5.ready, 1);
    send5(7, 16'h0071, 0, 1);
    chk("ill s5 ready d", s5.ready, 1);
    s5.valid = 1'b0;
    wait_empty5();
    chk("ill drop5", drop5, 2);
    sid5 = 3'd5;
    s5.data = 16'h5555;
    s5.valid = 1'b1;
    repeat (65531) @(posedge clock);
    #1;
    chk("sat drop5 near top", drop5, 16'hFFFD);
    repeat (6) @(posedge clock);
    #1;
    s5.valid = 1'b0;
    chk("sat drop5 saturated", drop5, 16'hFFFF);
    chk("sat s5 ready", s5.ready, 1);
    chk("sat m5 quiet", v5, 0);
    r8 = '0;
    send8(0, 16'hD0, 0, 0);
    send8(1, 16'hD1, 0, 0);
    s8.valid = 1'b0;
    chk("mid m8 stage valid", v8, 8'h01);
    chk("mid s8 skid full", s8.ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst m8 valid", v8, 0);
    chk("mid rst m8 data", d8[0], 0);
    chk("mid rst s8 ready", s8.ready, 0);
    chk("mid rst drop5", drop5, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    r8 = '1;
    repeat (5) @(posedge clock);
    #1;
    chk("post rst s8 ready", s8.ready, 1);
    chk("post rst m8 valid", v8, 0);
    chk("post rst queue", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
